video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Test-pattern source for the DVI path: emits a raster-ordered 24-bit pixel stream over the same
//  ready/valid interface the DVI controller consumes from the image buffer reader, so display timing
//  can be debugged without SRAM. Runs in the DVI pixel clock domain (50 MHz); selected by a top-level mux.
// PARAMETERS
//  WIDTH     800  active pixels per line
//  HEIGHT    600  active lines per frame
//  BAR_COUNT 8    number of vertical colour bars (WIDTH % BAR_COUNT == 0)
//  BOX_SIZE  32   side in pixels of the bouncing box (< WIDTH, < HEIGHT)
// PORTS
//  clock        in   1   pixel clock; all logic rising-edge
//  reset_n      in   1   asynchronous, active-low reset
//  enable       in   1   run request; sampled only at frame boundaries
//  mode         in   2   0 solid, 1 colour bars, 2 checkerboard, 3 bouncing box; sampled at frame boundaries
//  solid_rgb    in   24  colour for mode 0, {R,G,B}; sampled at frame boundaries
//  video        out  24  pixel {R[23:16],G[15:8],B[7:0]}
//  video_valid  out  1   video/video_sof hold a pixel
//  video_ready  in   1   consumer accepts when valid&&ready
//  video_sof    out  1   high with the pixel at (x=0,y=0)
//  frame_count  out  16  frames fully transferred, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async assert, sync release): video=0, video_valid=0, video_sof=0, frame_count=0, x=y=0,
//    box at (0,0) moving +1/+1, latched mode=0, latched enable=0. Reset mid-frame aborts the frame; no partial resume.
//  - Frame boundary = reset release or transfer of pixel (WIDTH-1,HEIGHT-1). At a boundary, latch enable,
//    mode and solid_rgb; changes mid-frame have no effect until next boundary.
//  - Output register: loaded when !video_valid || video_ready. While valid&&!ready, video, video_sof and
//    video_valid hold stable (no combinational ready->valid path). Zero bubbles under continuous ready:
//    one pixel per cycle.
//  - Latency: first valid pixel the 2nd rising edge after reset_n rises with enable=1 (1 cycle latch, 1 cycle register).
//  - If latched enable=0: video_valid=0 after the last pixel of the frame; re-check enable every cycle while
//    idle; on enable=1, next frame starts at (0,0) with sof.
//  - Counters: x increments on each transfer, wraps WIDTH-1->0 with y++; y wraps HEIGHT-1->0 at the boundary;
//    frame_count increments on that same transfer.
//  - Mode 1 bars: bar index i = x/(WIDTH/BAR_COUNT) via per-bar counter (no divider); c = 7-(i%8);
//    pixel = {{8{c[2]}},{8{c[1]}},{8{c[0]}}} -> white,yellow,cyan,green,magenta,red,blue,black.
//  - Mode 2 checker: pixel = (x[4]^y[4]) ? 24'hFFFFFF : 24'h000000.
//  - Mode 3 box: pixel = FFFFFF if box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE, else 202020.
//    At each boundary box moves by (dx,dy) in {+1,-1}; a coordinate reaching 0 or (dim-BOX_SIZE) reverses
//    its direction for the following frame. Both axes bounce independently; corners reverse both.
//  - Box position updates regardless of mode (continuous motion across mode switches).
//  - Mode 0: pixel = latched solid_rgb for the whole frame.
//  - FSM: IDLE (valid=0, wait latched enable) -> RUN (stream) -> at boundary: RUN if enable else IDLE.
// TESTING
//  1 reset_n low, enable=1, mode=1, ready=1; release -> 1st valid at edge 2, sof=1, video=FFFFFF;
//    pixel x=100 = FFFF00; x=700 = 000000; sof=0 on all other pixels.
//  2 mode=1, ready toggling pseudo-randomly 50% -> no pixel dropped/duplicated; video stable while
//    valid&&!ready; full frame = 480000 transfers then sof again, frame_count=1.
//  3 mode=2 mid-frame switch to 0 with solid_rgb=123456 -> rest of frame checkerboard
//    (pixel (16,0)=FFFFFF, (16,16)=000000); next frame all 123456.
//  4 mode=3, run 800 frames -> box_x sequence 0..768 then 767..; box_y reaches 568 at frame 568,
//    then decreases; box pixels FFFFFF, background 202020.
//  5 enable dropped mid-frame -> frame completes, valid=0 after pixel (799,599); re-enable -> sof at (0,0).
//  6 reset_n pulsed low mid-frame with valid&&!ready -> outputs 0 immediately (async); after release
//    restarts at (0,0), frame_count=0.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Raster-order test-pattern source with a ready/valid pixel output.
// Produces solid colour, colour bars, checkerboard or a bouncing box,
// with configuration captured only at frame boundaries.
module video_pattern_gen #(
  parameter int unsigned WIDTH     = 800,
  parameter int unsigned HEIGHT    = 600,
  parameter int unsigned BAR_COUNT = 8,
  parameter int unsigned BOX_SIZE  = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [23:0] video,
  output logic        video_valid,
  input  logic        video_ready,
  output logic        video_sof,
  output logic [15:0] frame_count
);

  // Counter widths never drop below 5 bits so the checkerboard bit 4 exists.
  localparam int unsigned XW    = ($clog2(WIDTH)  > 5) ? $clog2(WIDTH)  : 5;
  localparam int unsigned YW    = ($clog2(HEIGHT) > 5) ? $clog2(HEIGHT) : 5;
  localparam int unsigned BAR_W = WIDTH / BAR_COUNT;
  localparam int unsigned BIW   = ($clog2(BAR_COUNT) > 3) ? $clog2(BAR_COUNT) : 3;
  localparam int unsigned BCW   = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0]  X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic [XW-1:0]  BX_MAX   = XW'(WIDTH - BOX_SIZE);
  localparam logic [YW-1:0]  BY_MAX   = YW'(HEIGHT - BOX_SIZE);
  localparam logic [XW:0]    BOX_W    = (XW+1)'(BOX_SIZE);
  localparam logic [YW:0]    BOX_H    = (YW+1)'(BOX_SIZE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q;
  logic [23:0]    rgb_q;
  logic [XW-1:0]  gx;
  logic [YW-1:0]  gy;
  logic [BIW-1:0] bar_idx;
  logic [BCW-1:0] bar_cnt;
  logic [XW-1:0]  box_x, box_x_nx, bx_eff;
  logic [YW-1:0]  box_y, box_y_nx, by_eff;
  logic           box_dx, box_dy, box_dx_nx, box_dy_nx;  // 1 = moving toward 0
  logic           out_last;
  logic           boundary, load, drop;
  logic [1:0]     mode_eff;
  logic [23:0]    rgb_eff;
  logic [2:0]     bar_c;
  logic           in_box;
  logic [23:0]    pix;

  // The generator runs one pixel ahead of the output register, so pixel (0,0)
  // of a new frame is loaded on the very edge that transfers the last pixel.
  // That load must use the configuration being latched on that same edge,
  // hence the raw inputs and next box position are selected at a boundary.
  assign boundary = video_valid && video_ready && out_last;

  // Next-state and load/drop decode
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (boundary && !enable) begin
          state_d = IDLE;
          drop    = 1'b1;
        end else if (!video_valid || video_ready) begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Box motion for the next frame; reaching an edge flips that axis
  always_comb begin
    box_x_nx  = box_dx ? box_x - 1'b1 : box_x + 1'b1;
    box_y_nx  = box_dy ? box_y - 1'b1 : box_y + 1'b1;
    box_dx_nx = box_dx;
    box_dy_nx = box_dy;
    if (box_x_nx == '0 || box_x_nx == BX_MAX) box_dx_nx = ~box_dx;
    if (box_y_nx == '0 || box_y_nx == BY_MAX) box_dy_nx = ~box_dy;
  end

  // Pixel colour for the generator position
  always_comb begin
    mode_eff = boundary ? mode      : mode_q;
    rgb_eff  = boundary ? solid_rgb : rgb_q;
    bx_eff   = boundary ? box_x_nx  : box_x;
    by_eff   = boundary ? box_y_nx  : box_y;
    bar_c    = 3'd7 - bar_idx[2:0];
    in_box   = ({1'b0, gx} >= {1'b0, bx_eff}) && ({1'b0, gx} < {1'b0, bx_eff} + BOX_W) &&
               ({1'b0, gy} >= {1'b0, by_eff}) && ({1'b0, gy} < {1'b0, by_eff} + BOX_H);
    pix      = '0;
    case (mode_eff)
      2'd0:    pix = rgb_eff;
      2'd1:    pix = {{8{bar_c[2]}}, {8{bar_c[1]}}, {8{bar_c[0]}}};
      2'd2:    pix = (gx[4] ^ gy[4]) ? 24'hFFFFFF : 24'h000000;
      default: pix = in_box ? 24'hFFFFFF : 24'h202020;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Configuration latch: every idle cycle and at each frame boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= '0;
      rgb_q  <= '0;
    end else if (state_q == IDLE || boundary) begin
      mode_q <= mode;
      rgb_q  <= solid_rgb;
    end
  end

  // Raster position and bar counters, advanced per loaded pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gx      <= '0;
      gy      <= '0;
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (load) begin
      if (gx == X_LAST) begin
        gx      <= '0;
        bar_idx <= '0;
        bar_cnt <= '0;
        gy      <= (gy == Y_LAST) ? '0 : gy + 1'b1;
      end else begin
        gx <= gx + 1'b1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end
      end
    end
  end

  // Output register; holds while valid && !ready
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      video       <= '0;
      video_valid <= 1'b0;
      video_sof   <= 1'b0;
      out_last    <= 1'b0;
    end else if (load) begin
      video       <= pix;
      video_valid <= 1'b1;
      video_sof   <= (gx == '0) && (gy == '0);
      out_last    <= (gx == X_LAST) && (gy == Y_LAST);
    end else if (drop) begin
      video_valid <= 1'b0;
      video_sof   <= 1'b0;
      out_last    <= 1'b0;
    end
  end

  // Per-frame updates: box position and completed-frame counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      box_x       <= '0;
      box_y       <= '0;
      box_dx      <= 1'b0;
      box_dy      <= 1'b0;
      frame_count <= '0;
    end else if (boundary) begin
      box_x       <= box_x_nx;
      box_y       <= box_y_nx;
      box_dx      <= box_dx_nx;
      box_dy      <= box_dy_nx;
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a reduced 32x24 raster.
module tb_video_pattern_gen;

  localparam int W  = 32;
  localparam int H  = 24;
  localparam int BC = 8;
  localparam int B  = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = '0;
  logic [23:0] solid_rgb = '0;
  logic [23:0] video;
  logic        video_valid;
  logic        video_ready = 1'b0;
  logic        video_sof;
  logic [15:0] frame_count;

  video_pattern_gen #(.WIDTH(W), .HEIGHT(H), .BAR_COUNT(BC), .BOX_SIZE(B)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .solid_rgb(solid_rgb), .video(video), .video_valid(video_valid),
    .video_ready(video_ready), .video_sof(video_sof), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  logic [25:0] sb[$];  // {last, sof, rgb}
  int m_bx, m_by, m_dx, m_dy, m_fc, cx, cy, xfer_total;

  function automatic logic [23:0] ref_pix(input logic [1:0] m, input logic [23:0] rgb,
                                          input int bx, input int by, input int x, input int y);
    logic [2:0] c;
    int i;
    i = x / (W / BC);
    c = 3'(7 - (i % 8));
    case (m)
      2'd0:    return rgb;
      2'd1:    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
      2'd2:    return ((((x / 16) + (y / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return (x >= bx && x < bx + B && y >= by && y < by + B) ? 24'hFFFFFF : 24'h202020;
    endcase
  endfunction

  function automatic int tri_pos(input int f, input int m);
    int r;
    r = f % (2 * m);
    return (r <= m) ? r : 2 * m - r;
  endfunction

  function automatic void push_frame(input logic [1:0] m, input logic [23:0] rgb);
    logic lst, sf;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        lst = (x == W - 1) && (y == H - 1);
        sf  = (x == 0) && (y == 0);
        sb.push_back({lst, sf, ref_pix(m, rgb, m_bx, m_by, x, y)});
      end
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_fc = 0;
    cx = 0; cy = 0; xfer_total = 0;
  endfunction

  function automatic void model_boundary();
    m_fc = (m_fc + 1) % 65536;
    m_bx += m_dx;
    m_by += m_dy;
    if (m_bx == 0 || m_bx == W - B) m_dx = -m_dx;
    if (m_by == 0 || m_by == H - B) m_dy = -m_dy;
  endfunction

  // Pop the next expected pixel; at a frame end, advance the model and queue the next frame.
  task automatic sb_next(output logic [25:0] e, output int px, output int py, output bit empty);
    empty = (sb.size() == 0);
    px = cx; py = cy; e = '0;
    if (!empty) begin
      e = sb.pop_front();
      xfer_total++;
      if (cx == W - 1) begin cx = 0; cy = (cy == H - 1) ? 0 : cy + 1; end
      else cx++;
      if (e[25]) begin
        model_boundary();
        if (enable) push_frame(mode, solid_rgb);
      end
    end
  endtask

  task automatic tick(input logic rdy, output logic v, output logic s, output logic [23:0] p);
    video_ready = rdy;
    @(negedge clock);
    v = video_valid; s = video_sof; p = video;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic v, s; logic [23:0] p; logic [25:0] e; int px, py; bit emp; bit done = 0;
    reset_n = 0; enable = 1; mode = 2'd1; solid_rgb = '0; video_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({video_valid, video_sof, video, frame_count} !== 42'd0)
      $display("FAIL reset_outputs: got v=%b sof=%b rgb=%h fc=%0d, expected all zero", video_valid, video_sof, video, frame_count);
    else passes++;
    reset_n = 1;
    model_reset();
    push_frame(mode, solid_rgb);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, v, s, p);
      checks++;
      if (v !== 1'b0) $display("FAIL latency_early%0d: got valid=%b, expected 0", k, v);
      else passes++;
    end
    for (int n = 0; n < 200 && !done; n++) begin
      tick(1'b1, v, s, p);
      if (n == 0) begin
        checks++;
        if ({v, s, p} !== {1'b1, 1'b1, 24'hFFFFFF})
          $display("FAIL first_pixel: got v=%b sof=%b rgb=%h, expected v=1 sof=1 rgb=ffffff", v, s, p);
        else passes++;
      end
      if (v) begin
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
        if (py == 0 && (px == 4 || px == 28)) begin
          checks++;
          if (p !== ((px == 4) ? 24'hFFFF00 : 24'h000000))
            $display("FAIL bar_x%0d: got %h, expected %h", px, p, (px == 4) ? 24'hFFFF00 : 24'h000000);
          else passes++;
        end
        if (px == W - 1) done = 1;
      end
    end
    if (!done) begin checks++; $display("FAIL reset_line_timeout: got no line end, expected one"); end
  endtask

  task automatic test_backpressure();
    logic v, s, rdy, pv, ps; logic [23:0] p, pp; logic [25:0] e; int px, py; bit emp;
    bit hold = 0; bit done = 0;
    pv = 0; ps = 0; pp = '0;
    for (int n = 0; n < 8000 && !done; n++) begin
      rdy = 1'($urandom_range(0, 1));
      tick(rdy, v, s, p);
      if (hold) begin
        checks++;
        if ({v, s, p} !== {pv, ps, pp})
          $display("FAIL hold_stable: got v=%b sof=%b rgb=%h, expected v=%b sof=%b rgb=%h", v, s, p, pv, ps, pp);
        else passes++;
      end
      hold = v && !rdy; pv = v; ps = s; pp = p;
      if (v && rdy) begin
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
      end
      if (frame_count == 16'd1) done = 1;
    end
    checks++;
    if (!done || xfer_total != W * H)
      $display("FAIL frame_xfers: got %0d transfers at frame_count=%0d, expected %0d at 1", xfer_total, frame_count, W * H);
    else passes++;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      rdy = 1'($urandom_range(0, 1));
      tick(rdy, v, s, p);
      if (v && rdy) begin
        sb_next(e, px, py, emp);
        checks++;
        if (s !== 1'b1 || px != 0 || py != 0 || frame_count !== 16'd1)
          $display("FAIL next_sof: got sof=%b at (%0d,%0d) fc=%0d, expected sof=1 at (0,0) fc=1", s, px, py, frame_count);
        else passes++;
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
        done = 1;
      end
    end
    if (!done) begin checks++; $display("FAIL next_sof_timeout: got no transfer, expected one"); end
  endtask

  task automatic test_mode_switch();
    logic v, s; logic [23:0] p; logic [25:0] e; int px, py, fb; bit emp; bit done = 0;
    mode = 2'd2;
    for (int n = 0; n < 4000 && !done; n++) begin
      tick(1'b1, v, s, p);
      if (v) begin
        fb = m_fc;
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
        if (fb == 2 && px == 16 && (py == 0 || py == 16)) begin
          checks++;
          if (p !== ((py == 0) ? 24'hFFFFFF : 24'h000000))
            $display("FAIL checker_16_%0d: got %h, expected %h", py, p, (py == 0) ? 24'hFFFFFF : 24'h000000);
          else passes++;
        end
        if (fb == 2 && px == 0 && py == 3) begin mode = 2'd0; solid_rgb = 24'h123456; end
        if (fb == 3) begin
          checks++;
          if ({s, p} !== {1'b1, 24'h123456})
            $display("FAIL solid_next_frame: got sof=%b rgb=%h, expected sof=1 rgb=123456", s, p);
          else passes++;
          done = 1;
        end
      end
    end
    if (!done) begin checks++; $display("FAIL mode_switch_timeout: got no frame 3, expected one"); end
  endtask

  task automatic test_box();
    logic v, s; logic [23:0] p; logic [25:0] e; int px, py, fb, wc, wx, wy; bit emp; bit done = 0;
    mode = 2'd3; wc = 0; wx = -1; wy = -1;
    for (int n = 0; n < 40 * W * H && !done; n++) begin
      tick(1'b1, v, s, p);
      if (v) begin
        fb = m_fc;
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
        if (fb >= 4) begin
          if (p === 24'hFFFFFF) begin
            if (wc == 0) begin wx = px; wy = py; end
            wc++;
          end
          if (px == W - 1 && py == H - 1) begin
            checks++;
            if (wc != B * B || wx != tri_pos(fb, W - B) || wy != tri_pos(fb, H - B) || frame_count !== 16'(fb + 1))
              $display("FAIL box_frame%0d: got %0d white at (%0d,%0d) fc=%0d, expected %0d at (%0d,%0d) fc=%0d",
                       fb, wc, wx, wy, frame_count, B * B, tri_pos(fb, W - B), tri_pos(fb, H - B), fb + 1);
            else passes++;
            wc = 0; wx = -1; wy = -1;
          end
        end
        if (m_fc == 38) done = 1;
      end
    end
    if (!done) begin checks++; $display("FAIL box_timeout: got frame %0d, expected 38", m_fc); end
  endtask

  task automatic test_enable_drop();
    logic v, s; logic [23:0] p; logic [25:0] e; int px, py, idle; bit emp; bit seen_last = 0; bit done = 0;
    enable = 0; idle = 0;
    for (int n = 0; n < 2000 && !done; n++) begin
      tick(1'b1, v, s, p);
      if (seen_last) begin
        checks++;
        if (v !== 1'b0) $display("FAIL idle_valid: got valid=%b after last pixel, expected 0", v);
        else passes++;
        idle++;
        if (idle == 4) done = 1;
      end else if (v) begin
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
        if (e[25]) seen_last = 1;
      end
    end
    if (!done) begin checks++; $display("FAIL drop_timeout: got no idle period, expected one"); end
    enable = 1;
    push_frame(mode, solid_rgb);
    done = 0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick(1'b1, v, s, p);
      if (v) begin
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0] || s !== 1'b1 || px != 0 || py != 0)
          $display("FAIL reenable_sof: got sof=%b rgb=%h at (%0d,%0d), expected sof=1 rgb=%h at (0,0)", s, p, px, py, e[23:0]);
        else passes++;
        done = 1;
      end
    end
    if (!done) begin checks++; $display("FAIL reenable_timeout: got no pixel, expected one"); end
  endtask

  task automatic test_reset_mid();
    logic v, s; logic [23:0] p; logic [25:0] e; int px, py; bit emp; bit done = 0;
    for (int n = 0; n < 40; n++) begin
      tick(1'b1, v, s, p);
      if (v) begin
        sb_next(e, px, py, emp);
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
      end
    end
    tick(1'b0, v, s, p);
    tick(1'b0, v, s, p);
    checks++;
    if (v !== 1'b1) $display("FAIL pre_reset_valid: got valid=%b, expected 1", v);
    else passes++;
    #2 reset_n = 0;
    #1;
    checks++;
    if ({video_valid, video_sof, video, frame_count} !== 42'd0)
      $display("FAIL async_reset: got v=%b sof=%b rgb=%h fc=%0d, expected all zero", video_valid, video_sof, video, frame_count);
    else passes++;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    model_reset();
    push_frame(mode, solid_rgb);
    for (int n = 0; n < 80; n++) begin
      tick(1'b1, v, s, p);
      if (v) begin
        sb_next(e, px, py, emp);
        if (!done) begin
          checks++;
          if ({s, p} !== {1'b1, 24'hFFFFFF} || frame_count !== 16'd0 || px != 0 || py != 0)
            $display("FAIL restart: got sof=%b rgb=%h fc=%0d at (%0d,%0d), expected sof=1 rgb=ffffff fc=0 at (0,0)", s, p, frame_count, px, py);
          else passes++;
          done = 1;
        end
        checks++;
        if (emp || {s, p} !== e[24:0])
          $display("FAIL pixel (%0d,%0d): got sof=%b rgb=%h, expected sof=%b rgb=%h", px, py, s, p, e[24], e[23:0]);
        else passes++;
      end
    end
    if (!done) begin checks++; $display("FAIL restart_timeout: got no pixel, expected one"); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_mode_switch();
    test_box();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
